// File: rtl/msrv32_bus_pkg.sv
// Shared AHB-Lite encodings and data-phase owner encoding for the msrv32 memory arbiter.
package msrv32_bus_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_I    = 2'b01,
    OWN_D    = 2'b10
  } owner_e;

endpackage

// File: rtl/msrv32_mem_arbiter_if.sv
// Core fetch/load-store request ports and the AHB-Lite master port of the arbiter.
interface msrv32_mem_arbiter_if;
  logic        i_req_in;
  logic [31:0] i_addr_in;
  logic        i_gnt_out;
  logic        i_rvalid_out;
  logic [31:0] i_rdata_out;
  logic        i_err_out;

  logic        d_req_in;
  logic [31:0] d_addr_in;
  logic        d_wr_in;
  logic [1:0]  d_size_in;
  logic [31:0] d_wdata_in;
  logic [3:0]  d_wmask_in;
  logic        d_gnt_out;
  logic        d_rvalid_out;
  logic [31:0] d_rdata_out;
  logic        d_err_out;

  logic [31:0] haddr_out;
  logic [1:0]  htrans_out;
  logic        hwrite_out;
  logic [2:0]  hsize_out;
  logic [31:0] hwdata_out;
  logic [3:0]  hwmask_out;
  logic [31:0] hrdata_in;
  logic        hready_in;
  logic        hresp_in;

  // Arbiter side
  modport master (
    input  i_req_in, i_addr_in, d_req_in, d_addr_in, d_wr_in, d_size_in, d_wdata_in, d_wmask_in,
    input  hrdata_in, hready_in, hresp_in,
    output i_gnt_out, i_rvalid_out, i_rdata_out, i_err_out,
    output d_gnt_out, d_rvalid_out, d_rdata_out, d_err_out,
    output haddr_out, htrans_out, hwrite_out, hsize_out, hwdata_out, hwmask_out
  );

  // Core requesters plus bus slave
  modport slave (
    output i_req_in, i_addr_in, d_req_in, d_addr_in, d_wr_in, d_size_in, d_wdata_in, d_wmask_in,
    output hrdata_in, hready_in, hresp_in,
    input  i_gnt_out, i_rvalid_out, i_rdata_out, i_err_out,
    input  d_gnt_out, d_rvalid_out, d_rdata_out, d_err_out,
    input  haddr_out, htrans_out, hwrite_out, hsize_out, hwdata_out, hwmask_out
  );
endinterface

// File: rtl/msrv32_arb_prio.sv
// Data-first requester selection with a starvation limiter that forces a fetch grant.
module msrv32_arb_prio #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic i_fetch_req,
  input  logic i_data_req,
  input  logic i_accept,
  output logic o_sel_fetch,
  output logic o_sel_data
);

  localparam logic [3:0] LimitW = 4'(STARVE_LIMIT);

  logic [3:0] r_cnt;
  logic       w_starved;

  assign w_starved   = i_fetch_req && (r_cnt == LimitW);
  assign o_sel_data  = i_data_req && !w_starved;
  assign o_sel_fetch = !o_sel_data && i_fetch_req;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_cnt <= 4'd0;
    end else if (!i_fetch_req || (o_sel_fetch && i_accept)) begin
      r_cnt <= 4'd0;
    end else if (o_sel_data && i_accept && (r_cnt != LimitW)) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/msrv32_mem_arbiter.sv
// Shares one AHB-Lite master between instruction fetch and load/store, routing each
// data-phase response back to the requester that owns it.
module msrv32_mem_arbiter
  import msrv32_bus_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  msrv32_mem_arbiter_if.master  bus
);

  owner_e      r_owner;
  logic [31:0] r_hwdata;
  logic [3:0]  r_hwmask;

  logic w_sel_i, w_sel_d, w_err_cyc, w_accept, w_gnt_i, w_gnt_d;

  // First cycle of a two-cycle error response: the next address phase must not start.
  assign w_err_cyc = bus.hresp_in && !bus.hready_in;
  assign w_accept  = bus.hready_in && !w_err_cyc;
  assign w_gnt_i   = w_sel_i && w_accept;
  assign w_gnt_d   = w_sel_d && w_accept;

  msrv32_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .i_fetch_req (bus.i_req_in),
    .i_data_req  (bus.d_req_in),
    .i_accept    (w_accept),
    .o_sel_fetch (w_sel_i),
    .o_sel_data  (w_sel_d)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_owner  <= OWN_NONE;
      r_hwdata <= 32'd0;
      r_hwmask <= 4'd0;
    end else if (bus.hready_in) begin
      if (w_gnt_d) begin
        r_owner <= OWN_D;
        if (bus.d_wr_in) begin
          r_hwdata <= bus.d_wdata_in;
          r_hwmask <= bus.d_wmask_in;
        end
      end else if (w_gnt_i) begin
        r_owner <= OWN_I;
      end else begin
        r_owner <= OWN_NONE;
      end
    end
  end

  always_comb begin
    bus.htrans_out = HTRANS_IDLE;
    bus.haddr_out  = 32'd0;
    bus.hwrite_out = 1'b0;
    bus.hsize_out  = HSIZE_BYTE;
    if (!w_err_cyc) begin
      if (w_sel_d) begin
        bus.htrans_out = HTRANS_NONSEQ;
        bus.haddr_out  = bus.d_addr_in;
        bus.hwrite_out = bus.d_wr_in;
        bus.hsize_out  = {1'b0, bus.d_size_in};
      end else if (w_sel_i) begin
        bus.htrans_out = HTRANS_NONSEQ;
        bus.haddr_out  = bus.i_addr_in;
        bus.hsize_out  = HSIZE_WORD;
      end
    end
  end

  always_comb begin
    bus.i_rvalid_out = (r_owner == OWN_I) && bus.hready_in;
    bus.d_rvalid_out = (r_owner == OWN_D) && bus.hready_in;
    bus.i_rdata_out  = bus.i_rvalid_out ? bus.hrdata_in : 32'd0;
    bus.d_rdata_out  = bus.d_rvalid_out ? bus.hrdata_in : 32'd0;
    bus.i_err_out    = bus.i_rvalid_out && bus.hresp_in;
    bus.d_err_out    = bus.d_rvalid_out && bus.hresp_in;
  end

  assign bus.i_gnt_out  = w_gnt_i;
  assign bus.d_gnt_out  = w_gnt_d;
  assign bus.hwdata_out = r_hwdata;
  assign bus.hwmask_out = r_hwmask;

endmodule

// File: doc/msrv32_mem_arbiter.md
Name: msrv32_mem_arbiter

Overview:
Shares one AHB-Lite master port between the core's instruction-fetch requester and its load/store requester, so that a single unified memory can back the msrv32 core. The block sits between the core's instruction and data memory interfaces and the system bus. It sequences pipelined address and data phases, tracks which requester owns the data phase in flight, and routes read data and error responses back to that owner. Data accesses have priority; a starvation limiter guarantees fetch progress.

Parameters:
STARVE_LIMIT, 4, number of consecutive data grants with fetch pending before one fetch grant is forced (1..15)

Ports:
clk_in  input  1  core clock
rst_in  input  1  asynchronous, active-low reset
i_req_in  input  1  fetch request; held until i_gnt_out
i_addr_in  input  32  fetch address, word aligned
i_gnt_out  output  1  fetch address phase accepted this cycle
i_rvalid_out  output  1  fetch data phase complete this cycle
i_rdata_out  output  32  fetch data, valid with i_rvalid_out
i_err_out  output  1  fetch bus error, valid with i_rvalid_out
d_req_in  input  1  load/store request; held until d_gnt_out
d_addr_in  input  32  load/store address
d_wr_in  input  1  1 = store
d_size_in  input  2  00 byte, 01 half, 10 word
d_wdata_in  input  32  store data, sampled at grant
d_wmask_in  input  4  store byte mask, sampled at grant
d_gnt_out  output  1  data address phase accepted this cycle
d_rvalid_out  output  1  data phase complete this cycle
d_rdata_out  output  32  load data
d_err_out  output  1  load/store bus error
haddr_out  output  32  AHB address
htrans_out  output  2  AHB transfer type, IDLE or NONSEQ only
hwrite_out  output  1  AHB write
hsize_out  output  3  AHB size
hwdata_out  output  32  AHB write data, driven in the data phase
hwmask_out  output  4  byte mask aligned to the data phase
hrdata_in  input  32  AHB read data
hready_in  input  1  AHB ready
hresp_in  input  1  AHB error response

Behaviour:
- Reset, asynchronous and active-low: owner=NONE, starve counter=0, hwdata_out=0, hwmask_out=0. With no requests, all combinational outputs are 0 and htrans_out is IDLE (2'b00).
- Selection (combinational): the data requester is selected if d_req_in is high, unless i_req_in is high and the counter equals STARVE_LIMIT; otherwise the fetch requester is selected if i_req_in is high.
- Address phase: htrans_out=NONSEQ (2'b10) when a requester is selected; haddr, hwrite and hsize are muxed from that requester. Fetch always uses hwrite=0 and hsize=3'b010. Data uses hsize={1'b0,d_size_in}.
- Acceptance: the phase is accepted when a requester is selected, hready_in=1, and the cycle is not an error cycle. On acceptance, x_gnt_out=1 (same cycle), owner<=x, and for a data store hwdata_out<=d_wdata_in and hwmask_out<=d_wmask_in. Otherwise, if hready_in=1, owner<=NONE.
- Error cycle (hresp_in=1 and hready_in=0): htrans_out is forced to IDLE, no grant is given, and the requester must keep holding its request.
- Data phase completion: when owner=x and hready_in=1, x_rvalid_out=1, x_rdata_out=hrdata_in and x_err_out=hresp_in. The rvalid outputs are 0 whenever owner=NONE. Back-to-back transfers overlap: the data phase of N coincides with the address phase of N+1, so throughput is 1 transfer per cycle with zero wait states.
- Wait states: while hready_in=0, the address-phase outputs and owner are held, and no gnt or rvalid is issued.
- Starve counter:
  - increments (saturating at STARVE_LIMIT) on a data grant while i_req_in=1;
  - clears on a fetch grant or whenever i_req_in=0.
- Simultaneous requests with counter below the limit: data wins and fetch waits.
- Reset asserted mid-transfer: owner is cleared, the in-flight response is dropped, and no rvalid is issued after reset deasserts.
- Minimum latency is 1 cycle from gnt to rvalid.

Decomposition:
- Package msrv32_bus_pkg: HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10, HSIZE_BYTE/HALF/WORD, and owner encoding OWN_NONE/OWN_I/OWN_D.
- Sub-module msrv32_arb_prio: the selection logic plus the starve counter, parameterised by STARVE_LIMIT.
- The top level holds the owner register, the write-data register and the response routing.

Test Plan:
- Fetch only, i_addr=0x100, hready=1, hrdata=0x00000013: i_gnt in cycle 0, i_rvalid in cycle 1 with rdata 0x13, htrans NONSEQ then IDLE.
- Fetch and store together, store addr=0x2000, wdata=0xDEADBEEF, mask=4'hF: d_gnt first with hwrite=1 and hsize=3'b010, hwdata=0xDEADBEEF in the next cycle while fetch is granted, then i_rvalid one cycle later.
- Continuous d_req with i_req held and STARVE_LIMIT=4: 4 data grants, then 1 fetch grant, then data resumes and the counter reads 0.
- Slave inserts 2 wait states on a load of 0x3004: d_rvalid only in the cycle hready=1, address outputs stable throughout, no new gnt during the wait.
- Error response on a store: error cycle gives htrans IDLE and no gnt; the final cycle gives d_rvalid=1 and d_err=1; a pending fetch is granted afterwards.
- Reset pulled low during the data phase of a load: owner cleared, outputs IDLE, no d_rvalid after release.
